// File: rtl/datapath_pkg.sv
// Shared types for the datapath pipe: ALU and shifter opcodes, NZCV flag layout.
// Latency: none (declarations only).
// Backpressure: not applicable.
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_MOV  = 3'b101,
    ALU_BIC  = 3'b110,
    ALU_ZERO = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Bit positions of the flags on status_out.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // First member is the MSB, so the packed layout matches the FLAG_* indices.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational barrel shifter: LSL, LSR, ASR, ROR of data_in by amount.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module barrel_shifter
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SW-1:0]    amount,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] data_out
);

  logic [SW-1:0] rot_left;

  // Rotate right by k equals (x >> k) | (x << (WIDTH-k)); WIDTH-k taken mod WIDTH
  // makes k=0 collapse to x | x, so a zero amount passes data through.
  always_comb begin
    rot_left = ~amount + SW'(1);
    data_out = data_in;
    case (op)
      SH_LSL:  data_out = data_in << amount;
      SH_LSR:  data_out = data_in >> amount;
      SH_ASR:  data_out = WIDTH'($signed(data_in) >>> amount);
      SH_ROR:  data_out = (data_in >> amount) | (data_in << rot_left);
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Three-stage (ID/EX/WB) datapath: register file, barrel shifter, ALU, NZCV flags.
// Latency: result strobe and register write 2 edges after the accept edge; flags 1 edge after.
// Backpressure: DATAPATH_PIPE_FORWARD_EN defined -> forwarding, in_ready always 1;
//               undefined -> in_ready drops while a source matches a pending EX/WB destination.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS),
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    A_addr,
  input  logic [AW-1:0]    B_addr,
  input  logic [AW-1:0]    shift_addr,
  input  logic [WIDTH-1:0] imme_data,
  input  logic [SW-1:0]    shift_imme,
  input  logic             sel_A,
  input  logic             sel_B,
  input  logic             sel_shift,
  input  logic [1:0]       shift_op,
  input  logic [2:0]       ALU_op,
  input  logic             en_status,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  output logic             out_valid,
  output logic [WIDTH-1:0] datapath_out,
  output logic [3:0]       status_out
);

  // ID -> EX stage
  logic             ex_vld_q, ex_vld_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic             ex_sel_b_q, ex_sel_b_d;
  logic [SW-1:0]    ex_sh_amt_q, ex_sh_amt_d;
  shift_op_e        ex_sh_op_q, ex_sh_op_d;
  alu_op_e          ex_alu_q, ex_alu_d;
  logic             ex_en_st_q, ex_en_st_d;
  logic             ex_we_q, ex_we_d;
  logic [AW-1:0]    ex_waddr_q, ex_waddr_d;

  // EX -> WB stage
  logic             wb_vld_q, wb_vld_d;
  logic             wb_we_q, wb_we_d;
  logic [AW-1:0]    wb_waddr_q, wb_waddr_d;
  logic [WIDTH-1:0] wb_res_q, wb_res_d;

  // Architectural state and outputs
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  flags_t           status_q, status_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  // EX combinational
  logic [WIDTH-1:0] b_shift, b_op, ex_res;
  logic [WIDTH:0]   sum, diff;
  logic             carry, ovf;
  logic             accept;

  // Source read: register file, overridden by the write landing this cycle, and
  // (with forwarding) by the result being computed in EX, which is the youngest.
  function automatic logic [WIDTH-1:0] read_src(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = rf_q[addr];
    if (wb_vld_q && wb_we_q && (wb_waddr_q == addr)) val = wb_res_q;
`ifdef DATAPATH_PIPE_FORWARD_EN
    if (ex_vld_q && ex_we_q && (ex_waddr_q == addr)) val = ex_res;
`endif
    return val;
  endfunction

`ifdef DATAPATH_PIPE_FORWARD_EN
  assign in_ready = 1'b1;
`else
  logic a_used, b_used, s_used, hazard;

  function automatic logic pending(input logic [AW-1:0] addr);
    return (ex_vld_q && ex_we_q && (ex_waddr_q == addr)) ||
           (wb_vld_q && wb_we_q && (wb_waddr_q == addr));
  endfunction

  // Stall while any register the offered instruction actually reads is still in flight.
  always_comb begin
    a_used = !sel_A && (ALU_op != ALU_MOV) && (ALU_op != ALU_ZERO);
    b_used = !sel_B;
    s_used = !sel_B && sel_shift;
    hazard = (a_used && pending(A_addr)) ||
             (b_used && pending(B_addr)) ||
             (s_used && pending(shift_addr));
  end

  assign in_ready = !hazard;
`endif

  // ID: accept the offered instruction and capture its resolved operands.
  always_comb begin
    accept      = in_valid && in_ready;
    ex_vld_d    = accept;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_imm_d    = ex_imm_q;
    ex_sel_b_d  = ex_sel_b_q;
    ex_sh_amt_d = ex_sh_amt_q;
    ex_sh_op_d  = ex_sh_op_q;
    ex_alu_d    = ex_alu_q;
    ex_en_st_d  = ex_en_st_q;
    ex_we_d     = ex_we_q;
    ex_waddr_d  = ex_waddr_q;
    if (accept) begin
      ex_a_d      = sel_A ? '0 : read_src(A_addr);
      ex_b_d      = read_src(B_addr);
      ex_imm_d    = imme_data;
      ex_sel_b_d  = sel_B;
      ex_sh_amt_d = sel_shift ? SW'(read_src(shift_addr)) : shift_imme;
      ex_sh_op_d  = shift_op_e'(shift_op);
      ex_alu_d    = alu_op_e'(ALU_op);
      ex_en_st_d  = en_status;
      ex_we_d     = wb_en;
      ex_waddr_d  = wb_addr;
    end
  end

  barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data_in  (ex_b_q),
    .amount   (ex_sh_amt_q),
    .op       (ex_sh_op_q),
    .data_out (b_shift)
  );

  // EX: ALU; carry/overflow default to the held flags so logical ops keep C and V.
  always_comb begin
    b_op   = ex_sel_b_q ? ex_imm_q : b_shift;
    sum    = {1'b0, ex_a_q} + {1'b0, b_op};
    diff   = {1'b0, ex_a_q} - {1'b0, b_op};
    ex_res = '0;
    carry  = status_q.c;
    ovf    = status_q.v;
    case (ex_alu_q)
      ALU_ADD: begin
        ex_res = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (ex_a_q[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      ALU_SUB: begin
        ex_res = diff[WIDTH-1:0];
        carry  = !diff[WIDTH];
        ovf    = (ex_a_q[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      ALU_AND: ex_res = ex_a_q & b_op;
      ALU_ORR: ex_res = ex_a_q | b_op;
      ALU_EOR: ex_res = ex_a_q ^ b_op;
      ALU_MOV: ex_res = b_op;
      ALU_BIC: ex_res = ex_a_q & ~b_op;
      default: ex_res = '0;
    endcase
  end

  // EX end: flags update only for valid instructions that request it.
  always_comb begin
    status_d = status_q;
    if (ex_vld_q && ex_en_st_q) begin
      status_d.n = ex_res[WIDTH-1];
      status_d.z = (ex_res == '0);
      status_d.c = carry;
      status_d.v = ovf;
    end
  end

  // EX -> WB transfer, then WB writes the register file and drives the result port.
  always_comb begin
    wb_vld_d   = ex_vld_q;
    wb_we_d    = ex_we_q;
    wb_waddr_d = ex_waddr_q;
    wb_res_d   = ex_res;
    out_vld_d  = wb_vld_q;
    out_dat_d  = wb_vld_q ? wb_res_q : out_dat_q;
    rf_d       = rf_q;
    if (wb_vld_q && wb_we_q) rf_d[wb_waddr_q] = wb_res_q;
  end

  // All pipeline, flag, output and register-file state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q    <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_sel_b_q  <= 1'b0;
      ex_sh_amt_q <= '0;
      ex_sh_op_q  <= SH_LSL;
      ex_alu_q    <= ALU_ADD;
      ex_en_st_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_waddr_q  <= '0;
      wb_vld_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_waddr_q  <= '0;
      wb_res_q    <= '0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      status_q    <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      ex_vld_q    <= ex_vld_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_sel_b_q  <= ex_sel_b_d;
      ex_sh_amt_q <= ex_sh_amt_d;
      ex_sh_op_q  <= ex_sh_op_d;
      ex_alu_q    <= ex_alu_d;
      ex_en_st_q  <= ex_en_st_d;
      ex_we_q     <= ex_we_d;
      ex_waddr_q  <= ex_waddr_d;
      wb_vld_q    <= wb_vld_d;
      wb_we_q     <= wb_we_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_res_q    <= wb_res_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      status_q    <= status_d;
      rf_q        <= rf_d;
    end
  end

  // Output mapping onto the NZCV bit positions.
  always_comb begin
    out_valid          = out_vld_q;
    datapath_out       = out_dat_q;
    status_out         = '0;
    status_out[FLAG_N] = status_q.n;
    status_out[FLAG_Z] = status_q.z;
    status_out[FLAG_C] = status_q.c;
    status_out[FLAG_V] = status_q.v;
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: one 32-bit/16-reg and one 16-bit/8-reg instance,
// exercised in turn with the same directed program and width-scaled constants.
module tb_datapath_pipe;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_ORR = 3'd3,
                         OP_EOR = 3'd4, OP_MOV = 3'd5, OP_BIC = 3'd6, OP_ZRO = 3'd7;
  localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;

  typedef struct packed {
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [3:0]  s_addr;
    logic [3:0]  wa;
    logic [31:0] imm;
    logic [4:0]  shi;
    logic        sel_a;
    logic        sel_b;
    logic        sel_s;
    logic [1:0]  sop;
    logic [2:0]  op;
    logic        ens;
    logic        we;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg;        // 0 selects the 32-bit instance, 1 the 16-bit instance
  logic        in_valid;
  ins_t        cur;
  logic        rdy32, rdy16, v32, v16;
  logic [31:0] d32;
  logic [15:0] d16;
  logic [3:0]  s32, s16;
  logic        o_rdy, o_vld;
  logic [31:0] o_dat, mask;
  logic [3:0]  o_st;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          ofs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_pipe #(.WIDTH(32), .NREGS(16)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~cfg), .in_ready(rdy32),
    .A_addr(cur.a_addr), .B_addr(cur.b_addr), .shift_addr(cur.s_addr),
    .imme_data(cur.imm), .shift_imme(cur.shi),
    .sel_A(cur.sel_a), .sel_B(cur.sel_b), .sel_shift(cur.sel_s),
    .shift_op(cur.sop), .ALU_op(cur.op), .en_status(cur.ens),
    .wb_en(cur.we), .wb_addr(cur.wa),
    .out_valid(v32), .datapath_out(d32), .status_out(s32)
  );

  datapath_pipe #(.WIDTH(16), .NREGS(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & cfg), .in_ready(rdy16),
    .A_addr(cur.a_addr[2:0]), .B_addr(cur.b_addr[2:0]), .shift_addr(cur.s_addr[2:0]),
    .imme_data(cur.imm[15:0]), .shift_imme(cur.shi[3:0]),
    .sel_A(cur.sel_a), .sel_B(cur.sel_b), .sel_shift(cur.sel_s),
    .shift_op(cur.sop), .ALU_op(cur.op), .en_status(cur.ens),
    .wb_en(cur.we), .wb_addr(cur.wa[2:0]),
    .out_valid(v16), .datapath_out(d16), .status_out(s16)
  );

  assign o_rdy = cfg ? rdy16 : rdy32;
  assign o_vld = cfg ? v16 : v32;
  assign o_dat = cfg ? {16'h0000, d16} : d32;
  assign o_st  = cfg ? s16 : s32;
  assign mask  = cfg ? 32'h0000_FFFF : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cfg=%0d t=%0t)", tag, act, exp, cfg, $time);
    end
  endtask

  // Scoreboard: each result strobe pops the oldest expectation; latency is counted
  // from the cycle the instruction was offered and accepted.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    int          t0;
    if (rst_n && o_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(o_vld), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        t0 = ofs_q.pop_front();
        check("result", o_dat, e);
        check("latency", 32'(cyc - t0), 32'd3);
      end
    end
  end

  function automatic ins_t mk(input logic [2:0] op, input logic [3:0] wa,
                              input logic sel_a, input logic [3:0] aa,
                              input logic sel_b, input logic [3:0] ba, input logic [31:0] imm);
    ins_t t = '0;
    t.op = op; t.wa = wa; t.we = 1'b1;
    t.sel_a = sel_a; t.a_addr = aa;
    t.sel_b = sel_b; t.b_addr = ba; t.imm = imm;
    return t;
  endfunction

  function automatic ins_t shf(input ins_t t, input logic [1:0] sop, input logic sel_s,
                               input logic [3:0] sad, input logic [4:0] shi);
    ins_t r = t;
    r.sop = sop; r.sel_s = sel_s; r.s_addr = sad; r.shi = shi;
    return r;
  endfunction

  function automatic ins_t flg(input ins_t t);
    ins_t r = t;
    r.ens = 1'b1;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with in_valid low.
  task automatic issue(input ins_t ins, input logic [31:0] exp, output int stalls);
    stalls   = 0;
    cur      = ins;
    in_valid = 1'b1;
    #1;
    while (!o_rdy && stalls <= 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!o_rdy) begin
      check("issue_timeout", 32'(o_rdy), 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp & mask);
      ofs_q.push_back(cyc);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    ofs_q.delete();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(o_vld), 32'd0);
    check("rst_datapath_out", o_dat, 32'd0);
    check("rst_status", 32'(o_st), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", 32'(o_rdy), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_suite();
    int          st;
    logic [31:0] v_msb;
    v_msb = cfg ? 32'h0000_8000 : 32'h8000_0000;
    do_reset();

    // MOV r1,#5 then dependent ADD r2,r1,r1
    issue(mk(OP_MOV, 4'd1, 1'b1, 4'd0, 1'b1, 4'd0, 32'd5), 32'd5, st);
    issue(mk(OP_ADD, 4'd2, 1'b0, 4'd1, 1'b0, 4'd1, 32'd0), 32'd10, st);
`ifdef DATAPATH_PIPE_FORWARD_EN
    check("dep_stall_cycles", 32'(st), 32'd0);
`else
    check("dep_stall_cycles", 32'(st), 32'd2);
`endif
    drain();

    // ALU ops with r2=10 as A and an immediate B
    issue(mk(OP_AND, 4'd3, 1'b0, 4'd2, 1'b1, 4'd0, 32'd6),  32'd2,  st);
    issue(mk(OP_ORR, 4'd3, 1'b0, 4'd2, 1'b1, 4'd0, 32'd5),  32'd15, st);
    issue(mk(OP_EOR, 4'd3, 1'b0, 4'd2, 1'b1, 4'd0, 32'd15), 32'd5,  st);
    issue(mk(OP_BIC, 4'd3, 1'b0, 4'd2, 1'b1, 4'd0, 32'd2),  32'd8,  st);
    issue(mk(OP_SUB, 4'd3, 1'b0, 4'd2, 1'b1, 4'd0, 32'd3),  32'd7,  st);
    issue(mk(OP_ZRO, 4'd3, 1'b0, 4'd2, 1'b1, 4'd0, 32'd9),  32'd0,  st);
    issue(mk(OP_ADD, 4'd3, 1'b1, 4'd2, 1'b1, 4'd0, 32'd7),  32'd7,  st);
    // Immediate shifts of r2, including a zero rotate
    issue(shf(mk(OP_MOV, 4'd4, 1'b1, 4'd0, 1'b0, 4'd2, 32'd0), SH_LSL, 1'b0, 4'd0, 5'd3), 32'd80, st);
    issue(shf(mk(OP_MOV, 4'd4, 1'b1, 4'd0, 1'b0, 4'd2, 32'd0), SH_LSR, 1'b0, 4'd0, 5'd1), 32'd5,  st);
    issue(shf(mk(OP_MOV, 4'd4, 1'b1, 4'd0, 1'b0, 4'd2, 32'd0), SH_ROR, 1'b0, 4'd0, 5'd0), 32'd10, st);
    drain();

    // Signed-overflow SUB: (MSB-1) - all-ones
    issue(mk(OP_MOV, 4'd3, 1'b1, 4'd0, 1'b1, 4'd0, v_msb - 32'd1), v_msb - 32'd1, st);
    issue(mk(OP_MOV, 4'd4, 1'b1, 4'd0, 1'b1, 4'd0, mask), mask, st);
    issue(flg(mk(OP_SUB, 4'd5, 1'b0, 4'd3, 1'b0, 4'd4, 32'd0)), v_msb, st);
    drain();
    check("nzcv_sub_ovf", 32'(o_st), 32'b1001);
    // Flags hold without en_status, then ADD carry and logical keep of C/V
    issue(mk(OP_ADD, 4'd6, 1'b0, 4'd4, 1'b1, 4'd0, 32'd1), 32'd0, st);
    drain();
    check("nzcv_hold", 32'(o_st), 32'b1001);
    issue(flg(mk(OP_ADD, 4'd6, 1'b0, 4'd4, 1'b1, 4'd0, 32'd1)), 32'd0, st);
    drain();
    check("nzcv_add_carry", 32'(o_st), 32'b0110);
    issue(flg(mk(OP_EOR, 4'd6, 1'b0, 4'd4, 1'b1, 4'd0, 32'd0)), mask, st);
    drain();
    check("nzcv_logic_keep", 32'(o_st), 32'b1010);

    // ASR by register amount into r0, read r0 back; ROR by immediate 8
    issue(mk(OP_MOV, 4'd6, 1'b1, 4'd0, 1'b1, 4'd0, 32'd4), 32'd4, st);
    issue(mk(OP_MOV, 4'd7, 1'b1, 4'd0, 1'b1, 4'd0, v_msb), v_msb, st);
    issue(shf(mk(OP_MOV, 4'd0, 1'b1, 4'd0, 1'b0, 4'd7, 32'd0), SH_ASR, 1'b1, 4'd6, 5'd0),
          cfg ? 32'h0000_F800 : 32'hF800_0000, st);
    issue(mk(OP_ORR, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 32'd0),
          cfg ? 32'h0000_F800 : 32'hF800_0000, st);
    issue(mk(OP_MOV, 4'd3, 1'b1, 4'd0, 1'b1, 4'd0, 32'h0000_00AB), 32'h0000_00AB, st);
    issue(shf(mk(OP_MOV, 4'd4, 1'b1, 4'd0, 1'b0, 4'd3, 32'd0), SH_ROR, 1'b0, 4'd0, 5'd8),
          cfg ? 32'h0000_AB00 : 32'hAB00_0000, st);
    drain();

    // Reset with two writes in flight: nothing may emerge or land in the register file
    issue(mk(OP_MOV, 4'd1, 1'b1, 4'd0, 1'b1, 4'd0, 32'h33), 32'h33, st);
    issue(mk(OP_MOV, 4'd2, 1'b1, 4'd0, 1'b1, 4'd0, 32'h44), 32'h44, st);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("no_out_after_rst", 32'(o_vld), 32'd0);
      @(negedge clk);
    end
    issue(mk(OP_ORR, 4'd3, 1'b0, 4'd1, 1'b0, 4'd2, 32'd0), 32'd0, st);
    issue(mk(OP_MOV, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 32'd0), 32'd0, st);
    drain();
    check("status_after_rst", 32'(o_st), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cur      = '0;
    cfg      = 1'b0;
    @(negedge clk);
    run_suite();
    cfg = 1'b1;
    run_suite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath and register width in bits (minimum 8, power of two).
REQ-002 The block SHALL have parameter NREGS, default 16, register-file depth; AW = $clog2(NREGS), SW = $clog2(WIDTH).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-005 Issue ports SHALL be: in_valid  in  1  instruction offered; in_ready  out  1  instruction accepted when both high.
REQ-006 Operand ports SHALL be: A_addr, B_addr, shift_addr  in  AW each  source registers; imme_data  in  WIDTH  immediate; shift_imme  in  SW  immediate shift amount.
REQ-007 Control ports SHALL be: sel_A  in  1  force A to 0; sel_B  in  1  immediate replaces shifted B; sel_shift  in  1  shift amount from register, not immediate; shift_op  in  2; ALU_op  in  3; en_status  in  1.
REQ-008 Writeback ports SHALL be: wb_en  in  1  write result; wb_addr  in  AW  destination register.
REQ-009 Result ports SHALL be: out_valid  out  1  result strobe; datapath_out  out  WIDTH  result; status_out  out  4  NZCV flags, N in bit 3.

Function
REQ-010 The pipeline SHALL be three stages: ID (accept, read operands), EX (shift, ALU, flags), WB (register write, output).
REQ-011 An instruction accepted at edge N SHALL present out_valid=1 with its result in the cycle after edge N+2, and SHALL write the register file at edge N+2.
REQ-012 out_valid SHALL be a one-cycle strobe per accepted instruction; back-to-back issue SHALL give one result per cycle.
REQ-013 The shifter SHALL apply shift_op 00 LSL, 01 LSR, 10 ASR, 11 ROR to B, using shift_imme or the low SW bits of register shift_addr; an amount of 0 SHALL pass B unchanged.
REQ-014 ALU_op SHALL decode as: 000 ADD, 001 SUB (A-B), 010 AND, 011 ORR, 100 EOR, 101 MOV (B), 110 BIC (A & ~B), and 111 SHALL produce 0.
REQ-015 Results SHALL wrap modulo 2^WIDTH.
REQ-016 When en_status=1, status SHALL update at the end of EX as follows: N=result MSB; Z=result==0; for ADD, C=carry-out; for SUB, C=no-borrow; V=signed overflow for ADD/SUB; logical ops SHALL keep C and V.
REQ-017 With en_status=0, status SHALL hold.
REQ-018 Operand read hazards SHALL be resolved by forwarding (see REQ-024), with priority EX result over WB result over register file.
REQ-019 A forwarded source SHALL be one whose address equals the wb_addr of a valid, wb_en=1 older instruction.
REQ-020 sel_A=1 SHALL force A to 0 irrespective of forwarding.
REQ-021 Register 0 SHALL be an ordinary register with no hardwired zero.
REQ-022 A WB write and an ID read of the same address in the same cycle SHALL return the new data.

Reset
REQ-023 While rst_n=0, the block SHALL clear all stage valid bits, operand registers, status_out (0), datapath_out (0), out_valid (0) and every register-file entry; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-024 Macro DATAPATH_PIPE_FORWARD_EN defined SHALL compile forwarding in; in_ready is then constant 1 outside reset.
REQ-025 Without DATAPATH_PIPE_FORWARD_EN, in_ready SHALL be 0 while any source address used by the offered instruction matches a pending EX/WB destination; the block SHALL insert bubbles (no out_valid) until the hazard clears, and SHALL never return a stale operand.

Structure
REQ-026 A shared package datapath_pkg SHALL hold the ALU_op and shift_op enums, the NZCV bit-index constants and the flag struct.
REQ-027 The shifter SHALL be one sub-module, barrel_shifter, parametrised by WIDTH; the register file and ALU SHALL stay inline.

Verification
REQ-028 The bench SHALL apply reset, then issue MOV r1,#5 (sel_B=1, imme 5, wb r1): out_valid SHALL rise exactly 3 cycles after the accept edge with datapath_out=5.
REQ-029 The bench SHALL issue back-to-back MOV r1,#5; ADD r2,r1,r1: with forwarding, r2=10 with no bubble; without the macro, in_ready SHALL be 0 for 2 cycles and r2=10.
REQ-030 The bench SHALL issue SUB with A=0x7FFFFFFF, B=0xFFFFFFFF, en_status=1: result 0x80000000 and NZCV=1001.
REQ-031 The bench SHALL apply ASR by a register amount of 4 on 0x80000000, giving 0xF8000000; ROR by 8 on 0x000000AB, giving 0xAB000000.
REQ-032 The bench SHALL deassert rst_n mid-stream with 2 instructions in flight: no out_valid, no register write and status 0 SHALL follow, and reads SHALL return 0.
REQ-033 The bench SHALL repeat REQ-028 to REQ-031 with WIDTH=16, NREGS=8, using scaled values.
